// File: rtl/oven_controller.sv
// Oven sequencer: validates a cook request, preheats under a hysteresis
// thermostat, runs a seconds-resolution cook timer and waits for user ack.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a valid request; element off, model disabled
// PREHEAT | thermostat active, waiting for the model's preheated flag
// COOK    | thermostat active, cook timer counting down once per second
// DONE    | element off, model still enabled so the oven cools; wait ack
module oven_controller #(
  parameter int TICKS_PER_SEC = 10,
  parameter int HYST          = 2,
  parameter int T_MIN         = 150,
  parameter int T_MAX         = 550
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  tempIn,
  input  logic [11:0] cookSeconds,
  input  logic        tempValid,
  input  logic        cancel,
  input  logic        ack,
  input  logic [9:0]  currentTemp,
  input  logic        preheated,
  output logic [9:0]  targetTemp,
  output logic        tempInputDone,
  output logic        heat,
  output logic [11:0] remaining,
  output logic [1:0]  state,
  output logic        done,
  output logic        err
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [10:0]   T_MIN_W   = 11'(T_MIN);
  localparam logic [10:0]   T_MAX_W   = 11'(T_MAX);
  localparam logic [10:0]   HYST_W    = 11'(HYST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREHEAT = 2'd1,
    S_COOK    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [9:0]    target_q, target_n;
  logic [11:0]   dur_q, dur_n;
  logic [11:0]   rem_q, rem_n;
  logic [TW-1:0] tick_q, tick_n;
  logic          heat_q, heat_n;
  logic          done_q, done_n;
  logic          err_q, err_n;
  logic          tid_q, tid_n;

  logic          req_ok;
  logic          heat_on;
  logic          heat_off;
  logic          active_q;
  logic          active_n;

  assign req_ok = ({1'b0, tempIn} >= T_MIN_W) && ({1'b0, tempIn} <= T_MAX_W)
                  && (cookSeconds != 12'd0);

  // Adding HYST to the measurement instead of subtracting it from the target
  // keeps low targets from wrapping into a huge threshold.
  assign heat_on  = ({1'b0, currentTemp} + HYST_W) < {1'b0, target_q};
  assign heat_off = {1'b0, currentTemp} >= {1'b0, target_q};

  assign active_q = (state_q == S_PREHEAT) || (state_q == S_COOK);
  assign active_n = (state_n == S_PREHEAT) || (state_n == S_COOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      dur_q    <= '0;
      rem_q    <= '0;
      tick_q   <= '0;
      heat_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tid_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      target_q <= target_n;
      dur_q    <= dur_n;
      rem_q    <= rem_n;
      tick_q   <= tick_n;
      heat_q   <= heat_n;
      done_q   <= done_n;
      err_q    <= err_n;
      tid_q    <= tid_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    target_n = target_q;
    dur_n    = dur_q;
    rem_n    = rem_q;
    tick_n   = tick_q;
    heat_n   = heat_q;
    err_n    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tempValid && !cancel) begin
          if (req_ok) begin
            target_n = tempIn;
            dur_n    = cookSeconds;
            state_n  = S_PREHEAT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_PREHEAT: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (preheated) begin
          state_n = S_COOK;
          rem_n   = dur_q;
          tick_n  = '0;
        end
      end
      S_COOK: begin
        if (cancel) begin
          state_n = S_IDLE;
        end else if (tick_q == TICK_LAST) begin
          tick_n = '0;
          rem_n  = rem_q - 12'd1;
          if (rem_q == 12'd1) state_n = S_DONE;
        end else begin
          tick_n = tick_q + TW'(1);
        end
      end
      S_DONE: begin
        if (cancel || ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != S_COOK) tick_n = '0;
    if (state_n == S_IDLE) rem_n = '0;

    // Thermostat only runs while staying in the heating states, so the first
    // decision is made against the freshly latched target.
    if (active_q && active_n) begin
      if (heat_on)       heat_n = 1'b1;
      else if (heat_off) heat_n = 1'b0;
    end else begin
      heat_n = 1'b0;
    end

    done_n = (state_n == S_DONE);
    tid_n  = (state_n != S_IDLE);
  end

  assign state         = state_q;
  assign targetTemp    = target_q;
  assign remaining     = rem_q;
  assign heat          = heat_q;
  assign done          = done_q;
  assign err           = err_q;
  assign tempInputDone = tid_q;

endmodule

// File: tb/tb_oven_controller.sv
// Directed bench for oven_controller: reset, request validation, thermostat
// hysteresis, cook timing, cancel priority and mid-cook reset.
module tb_oven_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  tempIn;
  logic [11:0] cookSeconds;
  logic        tempValid;
  logic        cancel;
  logic        ack;
  logic [9:0]  currentTemp;
  logic        preheated;
  logic [9:0]  targetTemp;
  logic        tempInputDone;
  logic        heat;
  logic [11:0] remaining;
  logic [1:0]  state;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  oven_controller #(
    .TICKS_PER_SEC(10), .HYST(2), .T_MIN(150), .T_MAX(550)
  ) dut (
    .clk(clk), .rst(rst), .tempIn(tempIn), .cookSeconds(cookSeconds),
    .tempValid(tempValid), .cancel(cancel), .ack(ack),
    .currentTemp(currentTemp), .preheated(preheated),
    .targetTemp(targetTemp), .tempInputDone(tempInputDone), .heat(heat),
    .remaining(remaining), .state(state), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_target"}, 32'(targetTemp), 0);
    chk({tag, "_rem"}, 32'(remaining), 0);
    chk({tag, "_heat"}, 32'(heat), 0);
    chk({tag, "_tid"}, 32'(tempInputDone), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic submit(input logic [9:0] t, input logic [11:0] s);
    tempIn = t; cookSeconds = s; tempValid = 1'b1;
    step();
    tempValid = 1'b0;
  endtask

  logic [9:0] sweep_t [6];
  logic       sweep_h [6];
  logic [9:0] rej_t   [3];
  logic [11:0] rej_s  [3];

  initial begin
    sweep_t = '{10'd340, 10'd348, 10'd349, 10'd350, 10'd349, 10'd347};
    sweep_h = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rej_t   = '{10'd600, 10'd100, 10'd350};
    rej_s   = '{12'd3, 12'd3, 12'd0};

    rst = 1'b1; tempIn = '0; cookSeconds = '0; tempValid = 1'b0;
    cancel = 1'b0; ack = 1'b0; currentTemp = 10'd65; preheated = 1'b0;
    step(2);
    chk_reset("rst");
    rst = 1'b0;
    step();
    chk_reset("post_rst");

    for (int i = 0; i < 3; i++) begin
      submit(rej_t[i], rej_s[i]);
      chk($sformatf("rej%0d_err", i), 32'(err), 1);
      chk($sformatf("rej%0d_state", i), 32'(state), 0);
      chk($sformatf("rej%0d_target", i), 32'(targetTemp), 0);
      step();
      chk($sformatf("rej%0d_err_clr", i), 32'(err), 0);
    end

    submit(10'd350, 12'd3);
    chk("acc_state", 32'(state), 1);
    chk("acc_target", 32'(targetTemp), 350);
    chk("acc_tid", 32'(tempInputDone), 1);
    chk("acc_rem", 32'(remaining), 0);
    chk("acc_heat0", 32'(heat), 0);
    step();
    chk("acc_heat1", 32'(heat), 1);

    submit(10'd200, 12'd5);
    chk("ign_target", 32'(targetTemp), 350);
    chk("ign_err", 32'(err), 0);
    chk("ign_state", 32'(state), 1);

    for (int i = 0; i < 6; i++) begin
      currentTemp = sweep_t[i];
      step();
      chk($sformatf("thermo_%0d", sweep_t[i]), 32'(heat), 32'(sweep_h[i]));
    end

    preheated = 1'b1;
    step();
    preheated = 1'b0;
    chk("cook_state", 32'(state), 2);
    chk("cook_rem3", 32'(remaining), 3);
    step(9);
    chk("cook_rem3_hold", 32'(remaining), 3);
    step();
    chk("cook_rem2", 32'(remaining), 2);
    step(10);
    chk("cook_rem1", 32'(remaining), 1);
    step(9);
    chk("cook_still", 32'(state), 2);
    step();
    chk("done_state", 32'(state), 3);
    chk("done_done", 32'(done), 1);
    chk("done_heat", 32'(heat), 0);
    chk("done_tid", 32'(tempInputDone), 1);
    chk("done_rem", 32'(remaining), 0);

    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_state", 32'(state), 0);
    chk("ack_done", 32'(done), 0);
    chk("ack_tid", 32'(tempInputDone), 0);
    chk("ack_target", 32'(targetTemp), 350);

    currentTemp = 10'd65;
    submit(10'd200, 12'd1);
    chk("c_pre_state", 32'(state), 1);
    preheated = 1'b1;
    step();
    preheated = 1'b0;
    chk("c_cook_rem", 32'(remaining), 1);
    step(9);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("c_state", 32'(state), 0);
    chk("c_done", 32'(done), 0);
    chk("c_rem", 32'(remaining), 0);
    chk("c_heat", 32'(heat), 0);
    chk("c_target", 32'(targetTemp), 200);

    cancel = 1'b1;
    submit(10'd300, 12'd4);
    cancel = 1'b0;
    chk("ci_state", 32'(state), 0);
    chk("ci_err", 32'(err), 0);
    chk("ci_target", 32'(targetTemp), 200);

    submit(10'd350, 12'd3);
    preheated = 1'b1;
    step();
    preheated = 1'b0;
    step(10);
    chk("mid_rem2", 32'(remaining), 2);
    rst = 1'b1;
    step();
    chk_reset("mid_rst");
    rst = 1'b0;
    step();
    submit(10'd350, 12'd3);
    chk("re_state", 32'(state), 1);
    chk("re_target", 32'(targetTemp), 350);
    chk("re_tid", 32'(tempInputDone), 1);
    step();
    chk("re_heat", 32'(heat), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
